lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
- Memory-access pipeline stage between the execute/AGU stage and the data-memory controller (mem_ctrl).
- Accepts one load, store or pass-through op per handshake from EX and checks alignment and size encoding.
- Drives the memory controller's request signals for MEM_LAT cycles, captures load data and presents a registered result to write-back with a valid/ready handshake.

Parameters:
- MEM_LAT, 1: cycles a memory request is held on the mem_ctrl interface (>=1); load data is sampled in the last cycle.
- XLEN, 64: data/address width (matches `BUS_WIDTH).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- ex_valid  input  1  EX op valid
- ex_ready  output  1  stage can accept op
- ex_rd_en  input  1  op is a load
- ex_wr_en  input  1  op is a store
- ex_byte_enable  input  8  size: 0x01/0x03/0x0F/0xFF
- ex_load_signed  input  1  sign-extend load
- ex_addr  input  XLEN  effective address
- ex_wr_data  input  XLEN  store data
- ex_alu_res  input  XLEN  result for non-memory ops
- ex_rd_idx  input  5  destination register
- ex_rd_we  input  1  op writes rd
- mem_rd_en  output  1  to mem_ctrl
- mem_wr_en  output  1  to mem_ctrl
- mem_byte_enble  output  8  to mem_ctrl
- mem_load_is_signed  output  1  to mem_ctrl
- mem_addr  output  XLEN  to mem_ctrl
- mem_wr_data  output  XLEN  to mem_ctrl
- mem_rd_data  input  XLEN  from mem_ctrl, already extended
- wb_valid  output  1  result valid
- wb_ready  input  1  WB accepts
- wb_rd_idx  output  5  destination register
- wb_rd_we  output  1  write rd
- wb_data  output  XLEN  result
- wb_excp  output  1  misaligned or illegal access
- wb_bad_addr  output  XLEN  faulting address (0 when no exception)

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; all outputs and registers 0; ex_ready=0 during reset.
- ex_ready = (state==IDLE) | (state==RESP & wb_ready). Handshake fires on ex_valid & ex_ready; all ex_* fields are latched into a request register on that edge.
- Classification of the latched op:
  - MEM: exactly one of rd_en/wr_en set.
  - PASS: neither set.
  - ILLEGAL: both set, or byte_enable not one of the four legal codes.
  - MISALIGNED: legal MEM op with addr[0]!=0 (half), addr[1:0]!=0 (word), or addr[2:0]!=0 (double); byte ops never misalign.
- Next state after a handshake: MEM and aligned goes to ACCESS with counter=MEM_LAT-1. PASS, ILLEGAL and MISALIGNED go straight to RESP.
- ACCESS:
  - mem_rd_en, mem_byte_enble, mem_addr, mem_wr_data and mem_load_is_signed are driven from the request register for all MEM_LAT cycles.
  - mem_wr_en is asserted only in the final ACCESS cycle, so each store writes exactly once.
  - The counter decrements each cycle. At counter==0, load data is captured from mem_rd_data and the stage moves to RESP.
- Outside ACCESS, all mem_* outputs are 0.
- RESP: wb_valid=1 and wb_* are stable until wb_ready.
  - Load: wb_data = captured data, wb_rd_we = req rd_we.
  - Store: wb_data = 0, wb_rd_we = 0.
  - PASS: wb_data = alu_res, wb_rd_we = req rd_we.
  - ILLEGAL/MISALIGNED: wb_excp=1, wb_bad_addr=addr, wb_rd_we=0, wb_data=0, and no memory access is issued.
- On wb_ready: go to IDLE, or if a new handshake fires in the same cycle, take that op's next state (back-to-back; PASS ops sustain 1/cycle).
- Latency: load/store with MEM_LAT=1 gives wb_valid 2 cycles after the handshake edge; PASS gives 1 cycle.
- Reset mid-ACCESS aborts the access; mem_wr_en is deasserted on that edge with no partial write.
- ex_valid while not ready is ignored (no latch).

Decomposition:
- Shared package/defines.v holds:
  - byte-enable size codes BE_B=8'h01, BE_H=8'h03, BE_W=8'h0F, BE_D=8'hFF;
  - state encodings LSU_IDLE/LSU_ACCESS/LSU_RESP;
  - `ZERO_WORD and `BUS_WIDTH.
- One natural sub-module: lsu_align_chk (combinational), taking rd_en, wr_en, byte_enable and addr[2:0] and returning illegal/misaligned.

Test Plan:
- Aligned load: ld addr=0x8000_0010, RAM holds 0x1122334455667788, MEM_LAT=1 -> mem_rd_en=1 for 1 cycle, then wb_valid with wb_data=0x1122334455667788 and wb_rd_we=1.
- Store: sw addr=0x8000_0004, data=0xDEADBEEF, MEM_LAT=3 -> mem_rd_en=0 throughout, mem_wr_en high only in 3rd ACCESS cycle, wb_rd_we=0; a readback lw returns 0xFFFFFFFFDEADBEEF when signed.
- Misaligned: lh addr=0x8000_0003 -> no mem_* activity, wb_excp=1, wb_bad_addr=0x8000_0003. Illegal: byte_enable=0x07 -> wb_excp=1.
- Backpressure: hold wb_ready=0 for 4 cycles in RESP -> wb_* stable, ex_ready=0; release -> next op accepted the same cycle.
- PASS stream: 5 consecutive PASS ops with wb_ready=1 -> 5 results on 5 consecutive cycles, in order.
- Reset mid-ACCESS (MEM_LAT=3, sd in cycle 2): rst=0 -> memory unchanged, all outputs 0 next cycle, IDLE afterwards.

Source files
------------

// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store stage: size codes, FSM states and bus constants.
package lsu_stage_pkg;

  localparam int BUS_WIDTH = 64;
  localparam logic [BUS_WIDTH-1:0] ZERO_WORD = '0;

  localparam logic [7:0] BE_B = 8'h01;
  localparam logic [7:0] BE_H = 8'h03;
  localparam logic [7:0] BE_W = 8'h0F;
  localparam logic [7:0] BE_D = 8'hFF;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic be_legal(input logic [7:0] be);
    return (be == BE_B) || (be == BE_H) || (be == BE_W) || (be == BE_D);
  endfunction

endpackage

// File: rtl/lsu_align_chk.sv
// Combinational legality and natural-alignment check for a memory op.
module lsu_align_chk
  import lsu_stage_pkg::*;
(
  input  logic       rd_en,
  input  logic       wr_en,
  input  logic [7:0] byte_enable,
  input  logic [2:0] addr_lo,
  output logic       illegal,
  output logic       misaligned
);

  logic is_mem;

  always_comb begin
    is_mem     = rd_en ^ wr_en;
    illegal    = (rd_en & wr_en) | (is_mem & ~be_legal(byte_enable));
    misaligned = 1'b0;
    // Byte accesses can never be misaligned; wider ones must be naturally aligned.
    if (is_mem && !illegal) begin
      unique case (byte_enable)
        BE_H:    misaligned = addr_lo[0];
        BE_W:    misaligned = |addr_lo[1:0];
        BE_D:    misaligned = |addr_lo;
        default: misaligned = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/lsu_stage.sv
// Memory-access stage: latches one op from EX, runs it against mem_ctrl, presents the result to WB.
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int XLEN    = BUS_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_rd_en,
  input  logic            ex_wr_en,
  input  logic [7:0]      ex_byte_enable,
  input  logic            ex_load_signed,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wr_data,
  input  logic [XLEN-1:0] ex_alu_res,
  input  logic [4:0]      ex_rd_idx,
  input  logic            ex_rd_we,
  output logic            mem_rd_en,
  output logic            mem_wr_en,
  output logic [7:0]      mem_byte_enble,
  output logic            mem_load_is_signed,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wr_data,
  input  logic [XLEN-1:0] mem_rd_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd_idx,
  output logic            wb_rd_we,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_excp,
  output logic [XLEN-1:0] wb_bad_addr
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  lsu_state_e       state;
  logic [CNT_W-1:0] cnt;

  logic             req_rd_en_p0;
  logic             req_wr_en_p0;
  logic [7:0]       req_be_p0;
  logic             req_signed_p0;
  logic [XLEN-1:0]  req_addr_p0;
  logic [XLEN-1:0]  req_wr_data_p0;
  logic [XLEN-1:0]  req_alu_res_p0;
  logic [4:0]       req_rd_idx_p0;
  logic             req_rd_we_p0;
  logic             req_excp_p0;
  logic [XLEN-1:0]  ld_data_p1;

  logic chk_illegal;
  logic chk_misaligned;
  logic in_access;
  logic in_resp;
  logic last_beat;
  logic hs;

  lsu_align_chk u_align_chk (
    .rd_en       (ex_rd_en),
    .wr_en       (ex_wr_en),
    .byte_enable (ex_byte_enable),
    .addr_lo     (ex_addr[2:0]),
    .illegal     (chk_illegal),
    .misaligned  (chk_misaligned)
  );

  assign in_access = (state == LSU_ACCESS);
  assign in_resp   = (state == LSU_RESP);
  assign last_beat = in_access && (cnt == '0);
  assign ex_ready  = rst && ((state == LSU_IDLE) || (in_resp && wb_ready));
  assign hs        = ex_valid && ex_ready;

  // p0: request register and FSM; p1: load data captured on the last access beat
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= LSU_IDLE;
      cnt            <= '0;
      req_rd_en_p0   <= 1'b0;
      req_wr_en_p0   <= 1'b0;
      req_be_p0      <= '0;
      req_signed_p0  <= 1'b0;
      req_addr_p0    <= '0;
      req_wr_data_p0 <= '0;
      req_alu_res_p0 <= '0;
      req_rd_idx_p0  <= '0;
      req_rd_we_p0   <= 1'b0;
      req_excp_p0    <= 1'b0;
      ld_data_p1     <= '0;
    end else if (hs) begin
      req_rd_en_p0   <= ex_rd_en;
      req_wr_en_p0   <= ex_wr_en;
      req_be_p0      <= ex_byte_enable;
      req_signed_p0  <= ex_load_signed;
      req_addr_p0    <= ex_addr;
      req_wr_data_p0 <= ex_wr_data;
      req_alu_res_p0 <= ex_alu_res;
      req_rd_idx_p0  <= ex_rd_idx;
      req_rd_we_p0   <= ex_rd_we;
      req_excp_p0    <= chk_illegal | chk_misaligned;
      if ((ex_rd_en ^ ex_wr_en) && !chk_illegal && !chk_misaligned) begin
        state <= LSU_ACCESS;
        cnt   <= CNT_W'(MEM_LAT - 1);
      end else begin
        state <= LSU_RESP;
      end
    end else if (in_resp && wb_ready) begin
      state <= LSU_IDLE;
    end else if (in_access) begin
      if (cnt == '0) begin
        state <= LSU_RESP;
        if (req_rd_en_p0) ld_data_p1 <= mem_rd_data;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    mem_rd_en          = in_access & req_rd_en_p0;
    mem_wr_en          = last_beat & req_wr_en_p0;
    mem_byte_enble     = in_access ? req_be_p0 : '0;
    mem_load_is_signed = in_access & req_signed_p0;
    mem_addr           = in_access ? req_addr_p0 : '0;
    mem_wr_data        = in_access ? req_wr_data_p0 : '0;
  end

  always_comb begin
    wb_valid    = in_resp;
    wb_rd_idx   = in_resp ? req_rd_idx_p0 : '0;
    wb_excp     = in_resp & req_excp_p0;
    wb_bad_addr = (in_resp && req_excp_p0) ? req_addr_p0 : '0;
    wb_rd_we    = in_resp & ~req_excp_p0 & ~req_wr_en_p0 & req_rd_we_p0;
    wb_data     = '0;
    if (in_resp && !req_excp_p0) begin
      if (req_rd_en_p0)       wb_data = ld_data_p1;
      else if (!req_wr_en_p0) wb_data = req_alu_res_p0;
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: behavioural memory + result model, plus literal spot checks.
`timescale 1ns/1ps
module tb_lsu_stage;
  import lsu_stage_pkg::*;

  localparam int XLEN = 64;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            ex_valid, ex_ready, ex_rd_en, ex_wr_en, ex_load_signed, ex_rd_we;
  logic [7:0]      ex_byte_enable;
  logic [XLEN-1:0] ex_addr, ex_wr_data, ex_alu_res;
  logic [4:0]      ex_rd_idx;
  logic            mem_rd_en, mem_wr_en, mem_load_is_signed;
  logic [7:0]      mem_byte_enble;
  logic [XLEN-1:0] mem_addr, mem_wr_data, mem_rd_data;
  logic            wb_valid, wb_ready, wb_rd_we, wb_excp;
  logic [4:0]      wb_rd_idx;
  logic [XLEN-1:0] wb_data, wb_bad_addr;

  logic            ex_valid_1, ex_ready_1;
  logic            mem_rd_en_1, mem_wr_en_1, mem_load_is_signed_1;
  logic [7:0]      mem_byte_enble_1;
  logic [XLEN-1:0] mem_addr_1, mem_wr_data_1, mem_rd_data_1;
  logic            wb_valid_1, wb_ready_1, wb_rd_we_1, wb_excp_1;
  logic [4:0]      wb_rd_idx_1;
  logic [XLEN-1:0] wb_data_1, wb_bad_addr_1;

  lsu_stage #(.MEM_LAT(LAT), .XLEN(XLEN)) u_dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd_en(ex_rd_en), .ex_wr_en(ex_wr_en), .ex_byte_enable(ex_byte_enable),
    .ex_load_signed(ex_load_signed), .ex_addr(ex_addr), .ex_wr_data(ex_wr_data),
    .ex_alu_res(ex_alu_res), .ex_rd_idx(ex_rd_idx), .ex_rd_we(ex_rd_we),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_byte_enble(mem_byte_enble),
    .mem_load_is_signed(mem_load_is_signed), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd_idx(wb_rd_idx), .wb_rd_we(wb_rd_we), .wb_data(wb_data),
    .wb_excp(wb_excp), .wb_bad_addr(wb_bad_addr)
  );

  lsu_stage #(.MEM_LAT(1), .XLEN(XLEN)) u_dut_lat1 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid_1), .ex_ready(ex_ready_1),
    .ex_rd_en(ex_rd_en), .ex_wr_en(ex_wr_en), .ex_byte_enable(ex_byte_enable),
    .ex_load_signed(ex_load_signed), .ex_addr(ex_addr), .ex_wr_data(ex_wr_data),
    .ex_alu_res(ex_alu_res), .ex_rd_idx(ex_rd_idx), .ex_rd_we(ex_rd_we),
    .mem_rd_en(mem_rd_en_1), .mem_wr_en(mem_wr_en_1), .mem_byte_enble(mem_byte_enble_1),
    .mem_load_is_signed(mem_load_is_signed_1), .mem_addr(mem_addr_1), .mem_wr_data(mem_wr_data_1),
    .mem_rd_data(mem_rd_data_1), .wb_valid(wb_valid_1), .wb_ready(wb_ready_1),
    .wb_rd_idx(wb_rd_idx_1), .wb_rd_we(wb_rd_we_1), .wb_data(wb_data_1),
    .wb_excp(wb_excp_1), .wb_bad_addr(wb_bad_addr_1)
  );

  typedef struct packed {
    logic        rd, wr;
    logic [7:0]  be;
    logic        sgn;
    logic [63:0] addr, wdata, alu;
    logic [4:0]  idx;
    logic        we;
  } op_t;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd_idx;
    logic        rd_we, excp;
    logic [63:0] bad;
    int          due;
  } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic ram_init;
  logic [63:0] ram [16];
  logic [63:0] sh  [16];
  exp_t expq[$];
  int   xfer_q[$];
  logic head_seen = 1'b0;
  logic [63:0] last_data = '0, last_bad = '0;
  logic last_excp = 1'b0;
  int   acc_n = 0, rd_n = 0, wr_n = 0, wr_at = 0, run = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ld_ext(input logic [63:0] word, input logic [2:0] off,
                                         input logic [7:0] be, input logic sgn);
    logic [63:0] v;
    v = word >> (8 * off);
    case (be)
      8'h01:   ld_ext = sgn ? {{56{v[7]}}, v[7:0]}   : {56'd0, v[7:0]};
      8'h03:   ld_ext = sgn ? {{48{v[15]}}, v[15:0]} : {48'd0, v[15:0]};
      8'h0F:   ld_ext = sgn ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
      default: ld_ext = v;
    endcase
  endfunction

  function automatic logic [63:0] st_merge(input logic [63:0] word, input logic [2:0] off,
                                           input logic [7:0] be, input logic [63:0] d);
    logic [63:0] r;
    int k;
    r = word;
    for (int i = 0; i < 8; i++) begin
      k = int'(off) + i;
      if (be[i] && k < 8) r[8*k +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  // mem_ctrl model: combinational extended read, byte-lane write on mem_wr_en
  always_comb mem_rd_data = mem_rd_en ?
    ld_ext(ram[mem_addr[6:3]], mem_addr[2:0], mem_byte_enble, mem_load_is_signed) : '0;
  always_comb mem_rd_data_1 = mem_rd_en_1 ?
    ld_ext(ram[mem_addr_1[6:3]], mem_addr_1[2:0], mem_byte_enble_1, mem_load_is_signed_1) : '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
      ram[2] <= 64'h1122334455667788;
    end else if (mem_wr_en) begin
      ram[mem_addr[6:3]] <= st_merge(ram[mem_addr[6:3]], mem_addr[2:0], mem_byte_enble, mem_wr_data);
    end
  end

  always @(negedge clk) begin
    run <= (mem_byte_enble != 8'h00) ? run + 1 : 0;
    if (mem_byte_enble != 8'h00) acc_n <= acc_n + 1;
    if (mem_rd_en) rd_n <= rd_n + 1;
    if (mem_wr_en) begin
      wr_n  <= wr_n + 1;
      wr_at <= run + 1;
    end
  end

  // Result model: what WB must see, derived from the op's size/alignment rules in program order
  task automatic model_op(input op_t o, input int acc, output exp_t e);
    logic mem, illegal, misal;
    int sz;
    logic [3:0] w;
    mem     = o.rd ^ o.wr;
    sz      = $countones(o.be);
    illegal = (o.rd && o.wr) || (mem && !(o.be inside {8'h01, 8'h03, 8'h0F, 8'hFF}));
    misal   = mem && !illegal && ((int'(o.addr[2:0]) % sz) != 0);
    w       = o.addr[6:3];
    e.rd_idx = o.idx;
    e.excp   = illegal || misal;
    e.bad    = e.excp ? o.addr : 64'd0;
    e.data   = '0;
    e.rd_we  = 1'b0;
    e.due    = acc + ((mem && !e.excp) ? LAT + 1 : 1);
    if (!e.excp) begin
      if (o.rd) begin
        e.data  = ld_ext(sh[w], o.addr[2:0], o.be, o.sgn);
        e.rd_we = o.we;
      end else if (o.wr) begin
        sh[w] = st_merge(sh[w], o.addr[2:0], o.be, o.wdata);
      end else begin
        e.data  = o.alu;
        e.rd_we = o.we;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst && wb_valid) begin
      if (expq.size() == 0) begin
        chk("wb_unexpected_valid", 64'd1, 64'd0);
      end else begin
        if (!head_seen) begin
          chk("wb_latency", 64'(cyc), 64'(expq[0].due));
          head_seen <= 1'b1;
        end
        chk("wb_data", wb_data, expq[0].data);
        chk("wb_rd_idx", 64'(wb_rd_idx), 64'(expq[0].rd_idx));
        chk("wb_rd_we", 64'(wb_rd_we), 64'(expq[0].rd_we));
        chk("wb_excp", 64'(wb_excp), 64'(expq[0].excp));
        chk("wb_bad_addr", wb_bad_addr, expq[0].bad);
        if (wb_ready) begin
          last_data <= wb_data;
          last_excp <= wb_excp;
          last_bad  <= wb_bad_addr;
          xfer_q.push_back(cyc);
          void'(expq.pop_front());
          head_seen <= 1'b0;
        end
      end
    end
  end

  function automatic op_t mk(input logic rd, input logic wr, input logic [7:0] be, input logic sgn,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [63:0] alu, input logic [4:0] idx, input logic we);
    op_t o;
    o.rd = rd; o.wr = wr; o.be = be; o.sgn = sgn; o.addr = addr;
    o.wdata = wdata; o.alu = alu; o.idx = idx; o.we = we;
    return o;
  endfunction

  task automatic issue(input op_t o, input bit track, output int waited);
    exp_t e;
    ex_rd_en = o.rd; ex_wr_en = o.wr; ex_byte_enable = o.be; ex_load_signed = o.sgn;
    ex_addr = o.addr; ex_wr_data = o.wdata; ex_alu_res = o.alu; ex_rd_idx = o.idx;
    ex_rd_we = o.we; ex_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!ex_ready && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    chk("ex_accept", 64'(ex_ready), 64'd1);
    if (ex_ready && track) begin
      model_op(o, cyc, e);
      expq.push_back(e);
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && expq.size() != 0; i++) @(posedge clk);
    chk("drain_pending", 64'(expq.size()), 64'd0);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ex_ready"}, 64'(ex_ready), 64'd0);
    chk({tag, "_mem_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({tag, "_mem_wr_en"}, 64'(mem_wr_en), 64'd0);
    chk({tag, "_mem_be"}, 64'(mem_byte_enble), 64'd0);
    chk({tag, "_mem_signed"}, 64'(mem_load_is_signed), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wr_data"}, mem_wr_data, 64'd0);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_wb_data"}, wb_data, 64'd0);
    chk({tag, "_wb_excp"}, 64'(wb_excp), 64'd0);
    chk({tag, "_wb_bad_addr"}, wb_bad_addr, 64'd0);
    chk({tag, "_wb_rd_we"}, 64'(wb_rd_we), 64'd0);
    chk({tag, "_wb_rd_idx"}, 64'(wb_rd_idx), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, a0, r0, w0, n0, t0;
    rst = 1'b0; ram_init = 1'b1; wb_ready = 1'b1; wb_ready_1 = 1'b1;
    ex_valid = 1'b0; ex_valid_1 = 1'b0;
    ex_rd_en = 1'b0; ex_wr_en = 1'b0; ex_byte_enable = '0; ex_load_signed = 1'b0;
    ex_addr = '0; ex_wr_data = '0; ex_alu_res = '0; ex_rd_idx = '0; ex_rd_we = 1'b0;
    for (int i = 0; i < 16; i++) sh[i] = '0;
    sh[2] = 64'h1122334455667788;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    chk("reset_ex_ready_lat1", 64'(ex_ready_1), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; ram_init = 1'b0;
    @(negedge clk);
    chk("idle_ex_ready", 64'(ex_ready), 64'd1);

    // MEM_LAT=1 instance: aligned ld, result two cycles after the handshake
    ex_rd_en = 1'b1; ex_wr_en = 1'b0; ex_byte_enable = 8'hFF; ex_load_signed = 1'b0;
    ex_addr = 64'h8000_0010; ex_rd_idx = 5'd5; ex_rd_we = 1'b1;
    @(posedge clk); #1;
    ex_valid_1 = 1'b1;
    @(negedge clk);
    chk("lat1_ex_ready", 64'(ex_ready_1), 64'd1);
    t0 = cyc;
    @(posedge clk); #1;
    ex_valid_1 = 1'b0;
    @(negedge clk);
    chk("lat1_mem_rd_en", 64'(mem_rd_en_1), 64'd1);
    chk("lat1_mem_addr", mem_addr_1, 64'h8000_0010);
    chk("lat1_wb_valid_early", 64'(wb_valid_1), 64'd0);
    @(negedge clk);
    chk("lat1_latency", 64'(cyc - t0), 64'd2);
    chk("lat1_wb_valid", 64'(wb_valid_1), 64'd1);
    chk("lat1_wb_data", wb_data_1, 64'h1122334455667788);
    chk("lat1_wb_rd_we", 64'(wb_rd_we_1), 64'd1);
    chk("lat1_mem_rd_en_off", 64'(mem_rd_en_1), 64'd0);
    @(posedge clk); #1;

    // Aligned ld on the MEM_LAT=3 instance
    a0 = acc_n; r0 = rd_n;
    issue(mk(1, 0, 8'hFF, 0, 64'h8000_0010, 0, 0, 5'd5, 1), 1, w);
    drain();
    chk("ld_value", last_data, 64'h1122334455667788);
    chk("ld_rd_cycles", 64'(rd_n - r0), 64'(LAT));

    // sw: three access beats, write only on the last, no read strobe
    a0 = acc_n; r0 = rd_n; w0 = wr_n;
    issue(mk(0, 1, 8'h0F, 0, 64'h8000_0004, 64'hDEADBEEF, 0, 5'd6, 1), 1, w);
    drain();
    chk("sw_access_cycles", 64'(acc_n - a0), 64'(LAT));
    chk("sw_rd_cycles", 64'(rd_n - r0), 64'd0);
    chk("sw_wr_pulses", 64'(wr_n - w0), 64'd1);
    chk("sw_wr_beat", 64'(wr_at), 64'(LAT));
    chk("sw_ram", ram[0], 64'hDEADBEEF_0000_0000);

    issue(mk(1, 0, 8'h0F, 1, 64'h8000_0004, 0, 0, 5'd7, 1), 1, w);
    drain();
    chk("lw_signed", last_data, 64'hFFFFFFFF_DEADBEEF);
    issue(mk(1, 0, 8'h0F, 0, 64'h8000_0004, 0, 0, 5'd8, 1), 1, w);
    issue(mk(1, 0, 8'h01, 1, 64'h8000_0010, 0, 0, 5'd9, 1), 1, w);
    drain();
    chk("lb_signed", last_data, 64'hFFFFFFFF_FFFFFF88);
    issue(mk(1, 0, 8'h03, 0, 64'h8000_0016, 0, 0, 5'd10, 1), 1, w);
    issue(mk(0, 1, 8'h01, 0, 64'h8000_0031, 64'h55AB, 0, 5'd11, 1), 1, w);
    drain();

    // Faulting ops never reach the memory interface
    a0 = acc_n;
    issue(mk(1, 0, 8'h03, 1, 64'h8000_0003, 0, 0, 5'd12, 1), 1, w);
    drain();
    chk("misal_excp", 64'(last_excp), 64'd1);
    chk("misal_bad_addr", last_bad, 64'h8000_0003);
    issue(mk(1, 0, 8'h07, 0, 64'h8000_0010, 0, 0, 5'd13, 1), 1, w);
    drain();
    chk("illegal_be_excp", 64'(last_excp), 64'd1);
    issue(mk(1, 1, 8'hFF, 0, 64'h8000_0008, 0, 0, 5'd14, 1), 1, w);
    issue(mk(0, 1, 8'hFF, 0, 64'h8000_0024, 64'h1, 0, 5'd15, 1), 1, w);
    drain();
    chk("fault_no_access", 64'(acc_n - a0), 64'd0);

    // Backpressure: result held while WB stalls, next op accepted on release
    wb_ready = 1'b0;
    issue(mk(0, 0, 8'hFF, 0, 64'h0, 0, 64'h1234, 5'd7, 1), 1, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ex_ready", 64'(ex_ready), 64'd0);
      chk("bp_wb_valid", 64'(wb_valid), 64'd1);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    issue(mk(0, 0, 8'hFF, 0, 64'h0, 0, 64'h5678, 5'd8, 0), 1, w);
    chk("bp_release_accept_wait", 64'(w), 64'd0);
    drain();

    // PASS stream at one result per cycle
    n0 = xfer_q.size();
    for (int i = 0; i < 5; i++)
      issue(mk(0, 0, 8'hFF, 0, 64'h0, 0, 64'(100 + i * 7), 5'(16 + i), 1), 1, w);
    drain();
    chk("stream_count", 64'(xfer_q.size() - n0), 64'd5);
    for (int i = 1; i < 5; i++)
      chk("stream_consecutive", 64'(xfer_q[n0 + i] - xfer_q[n0 + i - 1]), 64'd1);

    // Reset in the second ACCESS beat of an sd: the write must never happen
    w0 = wr_n;
    issue(mk(0, 1, 8'hFF, 0, 64'h8000_0020, 64'hCAFEBABE_12345678, 0, 5'd3, 1), 0, w);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_wr_en", 64'(mem_wr_en), 64'd0);
    chk("abort_ex_ready", 64'(ex_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet("abort");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idle_ready", 64'(ex_ready), 64'd1);
    chk("abort_wr_pulses", 64'(wr_n - w0), 64'd0);
    chk("abort_ram", ram[4], 64'd0);
    @(posedge clk); #1;
    issue(mk(0, 0, 8'hFF, 0, 64'h0, 0, 64'hABCD, 5'd1, 1), 1, w);
    drain();

    for (int i = 0; i < 16; i++) chk("ram_final", ram[i], sh[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
